in_wrapper: RTL and testbench

IN_WRAPPER -- requirements
Module: in_wrapper

---
 rtl/in_wrapper_pkg.sv | 16 +
 rtl/in_wrapper_ctrl.sv | 52 +++++
 rtl/in_wrapper.sv | 52 +++++
 tb/tb_in_wrapper.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/in_wrapper_pkg.sv
// Shared definitions for the operand input wrapper: default word width and
// the 3-bit state encodings of the handshake FSM.
package in_wrapper_pkg;

   localparam int WIDTH_DEFAULT = 32;

   localparam logic [2:0] ST_IDLE_A  = 3'd0;
   localparam logic [2:0] ST_LOAD_A  = 3'd1;
   localparam logic [2:0] ST_ACK_A   = 3'd2;
   localparam logic [2:0] ST_IDLE_B  = 3'd3;
   localparam logic [2:0] ST_LOAD_B  = 3'd4;
   localparam logic [2:0] ST_ACK_B   = 3'd5;
   localparam logic [2:0] ST_START   = 3'd6;
   localparam logic [2:0] ST_WAIT_FP = 3'd7;

endpackage

// File: rtl/in_wrapper_ctrl.sv
// Handshake FSM: collects two operand words via a four-phase handshake,
// then issues a single start pulse and waits for the FP core to finish.
module in_wrapper_ctrl
   import in_wrapper_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inReady,
   input  logic doneFP,
   output logic loadA,
   output logic loadB,
   output logic inAccepted,
   output logic startFP,
   output logic busy
);

   logic [2:0] r_state;
   logic [2:0] w_state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE_A;
      end else begin
         r_state <= w_state_next;
      end
   end

   // inReady only matters in the collect states; doneFP only in WAIT_FP.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE_A:  if (inReady)  w_state_next = ST_LOAD_A;
         ST_LOAD_A:                w_state_next = ST_ACK_A;
         ST_ACK_A:   if (!inReady) w_state_next = ST_IDLE_B;
         ST_IDLE_B:  if (inReady)  w_state_next = ST_LOAD_B;
         ST_LOAD_B:                w_state_next = ST_ACK_B;
         ST_ACK_B:   if (!inReady) w_state_next = ST_START;
         ST_START:                 w_state_next = ST_WAIT_FP;
         ST_WAIT_FP: if (doneFP)   w_state_next = ST_IDLE_A;
         default:                  w_state_next = ST_IDLE_A;
      endcase
   end

   always_comb begin
      loadA      = (r_state == ST_LOAD_A);
      loadB      = (r_state == ST_LOAD_B);
      inAccepted = (r_state == ST_ACK_A) || (r_state == ST_ACK_B);
      startFP    = (r_state == ST_START);
      busy       = (r_state == ST_START) || (r_state == ST_WAIT_FP);
   end

endmodule

// File: rtl/in_wrapper.sv
// Operand input wrapper: two operand registers loaded from inBus under
// control of the handshake FSM in in_wrapper_ctrl.
module in_wrapper
   import in_wrapper_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] inBus,
   input  logic             inReady,
   output logic             inAccepted,
   input  logic             doneFP,
   output logic             startFP,
   output logic [WIDTH-1:0] opA,
   output logic [WIDTH-1:0] opB,
   output logic             busy
);

   logic             w_load_a;
   logic             w_load_b;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;

   in_wrapper_ctrl u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .inReady    (inReady),
      .doneFP     (doneFP),
      .loadA      (w_load_a),
      .loadB      (w_load_b),
      .inAccepted (inAccepted),
      .startFP    (startFP),
      .busy       (busy)
   );

   // The producer keeps inBus stable until it sees inAccepted, so the word
   // is captured directly on the edge leaving the load state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_a <= '0;
         r_op_b <= '0;
      end else begin
         if (w_load_a) r_op_a <= inBus;
         if (w_load_b) r_op_b <= inBus;
      end
   end

   assign opA = r_op_a;
   assign opB = r_op_b;

endmodule

// File: tb/tb_in_wrapper.sv
// Self-checking bench for in_wrapper: a transaction-level producer/FP-core
// model with randomized words, hold times, waits and bus noise.
module tb_in_wrapper;

   logic        clk;
   logic        rst;
   logic [31:0] inBus;
   logic        inReady;
   logic        inAccepted;
   logic        doneFP;
   logic        startFP;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;
   int start_cnt = 0;
   int exp_starts = 0;
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;

   in_wrapper #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .inBus      (inBus),
      .inReady    (inReady),
      .inAccepted (inAccepted),
      .doneFP     (doneFP),
      .startFP    (startFP),
      .opA        (opA),
      .opB        (opB),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each clock cycle with startFP high counts once; a correct op adds one.
   always @(posedge clk) begin
      if (startFP === 1'b1) start_cnt <= start_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, expected completion)");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, expv, $time);
      end
   endtask

   // Present one word and complete its four-phase handshake. Returns on the
   // negedge after inReady was dropped (the one-cycle inReady gap).
   task automatic send_word(input logic [31:0] w, input int hold, input bit is_a, input bit chk_lat);
      int n;
      inBus   = w;
      inReady = 1'b1;
      @(negedge clk);
      doneFP = 1'b0;
      n = 1;
      while (inAccepted !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("accept_seen", {31'd0, inAccepted}, 32'd1);
      if (chk_lat) check_val("accept_latency", n, 32'd2);
      if (is_a) exp_a = w; else exp_b = w;
      check_val("opA_after_load", opA, exp_a);
      check_val("opB_after_load", opB, exp_b);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold_accepted", {31'd0, inAccepted}, 32'd1);
         check_val("hold_opA", opA, exp_a);
         check_val("hold_opB", opB, exp_b);
         check_val("hold_busy", {31'd0, busy}, 32'd0);
      end
      inReady = 1'b0;
      inBus   = $urandom;
      @(negedge clk);
      check_val("release_accepted", {31'd0, inAccepted}, 32'd0);
   endtask

   // One full operation. early: doneFP pulsed in IDLE_B and in START.
   // lockout: producer presents 0xDEADBEEF throughout WAIT_FP.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold_a,
                         input int hold_b, input int wait_cyc, input bit early,
                         input bit lockout, input bit chk_lat_a);
      send_word(a, hold_a, 1'b1, chk_lat_a);
      if (early) doneFP = 1'b1;
      send_word(b, hold_b, 1'b0, 1'b1);
      // With one-cycle gaps this is the 7th cycle counting the A rise cycle.
      check_val("startFP_high", {31'd0, startFP}, 32'd1);
      check_val("busy_in_start", {31'd0, busy}, 32'd1);
      if (early) doneFP = 1'b1;
      @(negedge clk);
      doneFP = 1'b0;
      check_val("startFP_one_cycle", {31'd0, startFP}, 32'd0);
      check_val("busy_in_wait", {31'd0, busy}, 32'd1);
      for (int i = 0; i < wait_cyc; i++) begin
         if (lockout) begin
            inReady = 1'b1;
            inBus   = 32'hDEADBEEF;
         end else begin
            inReady = 1'($urandom_range(0, 1));
            inBus   = $urandom;
         end
         @(negedge clk);
         check_val("wait_accepted", {31'd0, inAccepted}, 32'd0);
         check_val("wait_busy", {31'd0, busy}, 32'd1);
         check_val("wait_startFP", {31'd0, startFP}, 32'd0);
         check_val("wait_opA", opA, exp_a);
         check_val("wait_opB", opB, exp_b);
      end
      doneFP = 1'b1;
      if (!lockout) inReady = 1'b0;
      @(negedge clk);
      doneFP = 1'b0;
      exp_starts++;
      check_val("busy_after_done", {31'd0, busy}, 32'd0);
      check_val("start_pulse_count", start_cnt, exp_starts);
   endtask

   initial begin
      rst     = 1'b1;
      inBus   = '0;
      inReady = 1'b0;
      doneFP  = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_opA", opA, 32'd0);
      check_val("reset_opB", opB, 32'd0);
      check_val("reset_accepted", {31'd0, inAccepted}, 32'd0);
      check_val("reset_startFP", {31'd0, startFP}, 32'd0);
      check_val("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Nominal operation with minimal timing.
      run_op(32'h3F800000, 32'h40000000, 0, 0, 3, 1'b0, 1'b0, 1'b1);

      // Slow producer release on A: held 5 extra cycles in the ack phase.
      run_op($urandom, $urandom, 5, 0, 2, 1'b0, 1'b0, 1'b1);

      // Busy lockout, then the waiting 0xDEADBEEF becomes the next A.
      run_op($urandom, $urandom, 0, 1, 4, 1'b0, 1'b1, 1'b1);
      run_op(32'hDEADBEEF, $urandom, 0, 0, 1, 1'b0, 1'b0, 1'b1);

      // Early doneFP in IDLE_B and START must be ignored.
      run_op($urandom, $urandom, 1, 0, 3, 1'b1, 1'b0, 1'b1);

      // Reset while in ACK_B discards both operands, no start afterwards.
      send_word(32'h12345678, 0, 1'b1, 1'b1);
      inBus   = 32'h9ABCDEF0;
      inReady = 1'b1;
      repeat (2) @(negedge clk);
      check_val("pre_reset_ackB", {31'd0, inAccepted}, 32'd1);
      check_val("pre_reset_opB", opB, 32'h9ABCDEF0);
      #2 rst = 1'b1;
      #1;
      check_val("async_reset_opA", opA, 32'd0);
      check_val("async_reset_opB", opB, 32'd0);
      check_val("async_reset_accepted", {31'd0, inAccepted}, 32'd0);
      inReady = 1'b0;
      exp_a = '0;
      exp_b = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check_val("post_reset_startFP", {31'd0, startFP}, 32'd0);
      end
      check_val("post_reset_start_count", start_cnt, exp_starts);
      check_val("post_reset_busy", {31'd0, busy}, 32'd0);

      // Back-to-back randomized operations.
      for (int k = 0; k < 10; k++) begin
         run_op($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
